// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// the hard-wired zero register index and the default watchdog limit.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } hazState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int DEFAULT_MEM_TIMEOUT = 64;
  localparam int TIMER_W = 16;

endpackage

// File: rtl/hazard_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: reset is sampled on the clock edge (synchronous, active-low), and all
  // clocked state is assigned with <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use, taken
// branch and data-memory wait hazards, plus a memory watchdog and statistics.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             exe_mem_read,
  input  logic [4:0]       exe_rd,
  input  logic             exe_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic             mem_wb_flush,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazState_t          state, nextState;
  logic [TIMER_W-1:0] waitTimer, nextTimer;

  logic memWait, loadUse, active;
  logic selWait, selBranch, selLoadUse, selNormal;

  // Hazard detection and priority select; active folds in reset and ERROR.
  always_comb begin
    memWait    = mem_req & ~mem_ack;
    loadUse    = exe_mem_read & (exe_rd != REG_ZERO) &
                 ((id_use_rs1 & (id_rs1 == exe_rd)) |
                  (id_use_rs2 & (id_rs2 == exe_rd)));
    active     = rst & (state != ST_ERROR);
    selWait    = active & memWait;
    // A branch held behind a memory wait is deferred, not dropped.
    selBranch  = active & ~memWait & exe_branch_taken;
    selLoadUse = active & ~memWait & ~exe_branch_taken & loadUse;
    selNormal  = active & ~memWait & ~exe_branch_taken & ~loadUse;
  end

  assign pc_en        = selNormal | selBranch;
  assign if_id_en     = selNormal | selBranch;
  assign id_exe_en    = active & ~memWait;
  assign exe_mem_en   = active & ~memWait;
  assign mem_wb_en    = active;
  assign if_id_flush  = selBranch;
  assign id_exe_flush = selBranch | selLoadUse;
  assign mem_wb_flush = selWait;
  assign mem_err      = (state == ST_ERROR);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextState = state;
    nextTimer = waitTimer;
    case (state)
      ST_RUN: begin
        if (memWait) begin
          nextState = ST_MEM_WAIT;
          nextTimer = TIMER_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!memWait) begin
          nextState = ST_RUN;
          nextTimer = '0;
        end else if (waitTimer == TIMER_W'(MEM_TIMEOUT - 1)) begin
          nextState = ST_ERROR;
          nextTimer = '0;
        end else begin
          nextTimer = waitTimer + 1'b1;
        end
      end
      ST_ERROR: begin
        nextState = ST_ERROR;
      end
      default: begin
        nextState = ST_RUN;
        nextTimer = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_RUN;
      waitTimer <= '0;
    end else begin
      state     <= nextState;
      waitTimer <= nextTimer;
    end
  end

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(selLoadUse), .count(stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk(clk), .rst(rst), .inc(selWait), .count(wait_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(selBranch), .count(flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (wide and 2-bit counters) against
// a cycle model derived from the hazard rules, plus directed literal checks.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT = 4;

  localparam logic [7:0] C_OFF  = 8'b00000_000;
  localparam logic [7:0] C_NORM = 8'b11111_000;
  localparam logic [7:0] C_WAIT = 8'b00001_001;
  localparam logic [7:0] C_BR   = 8'b11111_110;
  localparam logic [7:0] C_LU   = 8'b00111_010;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] idRs1, idRs2, exeRd;
  logic idUseRs1, idUseRs2, exeMemRead, exeBranchTaken, memReq, memAck;

  logic pcA, ifIdA, idExeA, exeMemA, memWbA, ifIdFlA, idExeFlA, memWbFlA, errA;
  logic pcB, ifIdB, idExeB, exeMemB, memWbB, ifIdFlB, idExeFlB, memWbFlB, errB;
  logic [15:0] stallA, waitA, flushA;
  logic [1:0]  stallB, waitB, flushB;
  logic [7:0]  ctlA, ctlB;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // model state
  bit mErr = 1'b0;
  int mRun = 0, mStall = 0, mWait = 0, mFlush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(16)) dutA (
    .clk(clk), .rst(rst), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2), .exe_mem_read(exeMemRead),
    .exe_rd(exeRd), .exe_branch_taken(exeBranchTaken), .mem_req(memReq),
    .mem_ack(memAck), .pc_en(pcA), .if_id_en(ifIdA), .id_exe_en(idExeA),
    .exe_mem_en(exeMemA), .mem_wb_en(memWbA), .if_id_flush(ifIdFlA),
    .id_exe_flush(idExeFlA), .mem_wb_flush(memWbFlA), .mem_err(errA),
    .stall_cnt(stallA), .wait_cnt(waitA), .flush_cnt(flushA)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .id_rs1(idRs1), .id_rs2(idRs2),
    .id_use_rs1(idUseRs1), .id_use_rs2(idUseRs2), .exe_mem_read(exeMemRead),
    .exe_rd(exeRd), .exe_branch_taken(exeBranchTaken), .mem_req(memReq),
    .mem_ack(memAck), .pc_en(pcB), .if_id_en(ifIdB), .id_exe_en(idExeB),
    .exe_mem_en(exeMemB), .mem_wb_en(memWbB), .if_id_flush(ifIdFlB),
    .id_exe_flush(idExeFlB), .mem_wb_flush(memWbFlB), .mem_err(errB),
    .stall_cnt(stallB), .wait_cnt(waitB), .flush_cnt(flushB)
  );

  assign ctlA = {pcA, ifIdA, idExeA, exeMemA, memWbA, ifIdFlA, idExeFlA, memWbFlA};
  assign ctlB = {pcB, ifIdB, idExeB, exeMemB, memWbB, ifIdFlB, idExeFlB, memWbFlB};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit modelWait();
    return memReq && !memAck;
  endfunction

  function automatic bit modelLoadUse();
    bit hit1, hit2;
    hit1 = idUseRs1 && (idRs1 == exeRd);
    hit2 = idUseRs2 && (idRs2 == exeRd);
    return exeMemRead && (exeRd != 5'd0) && (hit1 || hit2);
  endfunction

  function automatic logic [7:0] modelCtl();
    if (!rst || mErr) return C_OFF;
    if (modelWait()) return C_WAIT;
    if (exeBranchTaken) return C_BR;
    if (modelLoadUse()) return C_LU;
    return C_NORM;
  endfunction

  function automatic logic [63:0] sat(input int n, input int w);
    int top;
    top = (1 << w) - 1;
    return (n > top) ? 64'(top) : 64'(n);
  endfunction

  // Reference model: advances on each clock edge from the hazard rules.
  always @(posedge clk) begin
    if (!rst) begin
      mErr <= 1'b0; mRun <= 0; mStall <= 0; mWait <= 0; mFlush <= 0;
    end else if (!mErr) begin
      if (modelWait()) begin
        mWait <= mWait + 1;
        mRun  <= mRun + 1;
        if (mRun + 1 >= TIMEOUT) mErr <= 1'b1;
      end else begin
        mRun <= 0;
        if (exeBranchTaken) mFlush <= mFlush + 1;
        else if (modelLoadUse()) mStall <= mStall + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      check("ctlA", 64'(ctlA), 64'(modelCtl()));
      check("ctlB", 64'(ctlB), 64'(modelCtl()));
      check("errA", 64'(errA), 64'(mErr));
      check("errB", 64'(errB), 64'(mErr));
      check("stallA", 64'(stallA), sat(mStall, 16));
      check("waitA",  64'(waitA),  sat(mWait, 16));
      check("flushA", 64'(flushA), sat(mFlush, 16));
      check("stallB", 64'(stallB), sat(mStall, 2));
      check("waitB",  64'(waitB),  sat(mWait, 2));
      check("flushB", 64'(flushB), sat(mFlush, 2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    idRs1 = 5'd0; idRs2 = 5'd0; exeRd = 5'd0;
    idUseRs1 = 1'b0; idUseRs2 = 1'b0; exeMemRead = 1'b0;
    exeBranchTaken = 1'b0; memReq = 1'b0; memAck = 1'b0;
  endtask

  task automatic setLoadUse(input logic [4:0] rd);
    exeMemRead = 1'b1; exeRd = rd; idUseRs1 = 1'b1; idRs1 = 5'd5;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    clearIn();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    clearIn();
    tick();
    checkEn = 1'b1;
    #1 check("reset_ctl", 64'(ctlA), 64'(C_OFF));
    tick();
    check("reset_err", 64'(errA), 64'd0);
    check("reset_stall", 64'(stallA), 64'd0);
    rst = 1'b1;
    #1 check("run_normal", 64'(ctlA), 64'(C_NORM));
    tick();

    // load-use, then the same with rd = x0
    setLoadUse(5'd5);
    #1 check("lu_ctl", 64'(ctlA), 64'(C_LU));
    tick();
    check("lu_stall_cnt", 64'(stallA), 64'd1);
    setLoadUse(5'd0);
    idRs1 = 5'd0;
    #1 check("lu_x0_ctl", 64'(ctlA), 64'(C_NORM));
    tick();
    check("lu_x0_stall_cnt", 64'(stallA), 64'd1);
    clearIn();
    idUseRs2 = 1'b1; idRs2 = 5'd9; exeMemRead = 1'b1; exeRd = 5'd9;
    #1 check("lu_rs2_ctl", 64'(ctlA), 64'(C_LU));
    tick();

    // branch with coincident load-use
    resetDut();
    setLoadUse(5'd5);
    exeBranchTaken = 1'b1;
    #1 check("br_lu_ctl", 64'(ctlA), 64'(C_BR));
    tick();
    check("br_lu_flush_cnt", 64'(flushA), 64'd1);
    check("br_lu_stall_cnt", 64'(stallA), 64'd0);

    // three-cycle memory wait then ack
    resetDut();
    memReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("wait_ctl", 64'(ctlA), 64'(C_WAIT));
      tick();
    end
    memAck = 1'b1;
    #1 check("ack_ctl", 64'(ctlA), 64'(C_NORM));
    tick();
    check("wait_cnt3", 64'(waitA), 64'd3);
    clearIn();
    tick();

    // branch deferred behind a two-cycle wait
    resetDut();
    memReq = 1'b1; exeBranchTaken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1 check("defer_ctl", 64'(ctlA), 64'(C_WAIT));
      tick();
    end
    memAck = 1'b1;
    #1 check("defer_flush_ctl", 64'(ctlA), 64'(C_BR));
    tick();
    check("defer_flush_cnt", 64'(flushA), 64'd1);
    check("defer_wait_cnt", 64'(waitA), 64'd2);

    // timeout after the 4th consecutive wait cycle
    resetDut();
    memReq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pre_to_err", 64'(errA), 64'd0);
      tick();
    end
    check("to_err", 64'(errA), 64'd1);
    check("to_ctl", 64'(ctlA), 64'(C_OFF));
    clearIn();
    setLoadUse(5'd5);
    tick();
    check("to_sticky", 64'(errA), 64'd1);
    check("to_frozen_wait", 64'(waitA), 64'd4);
    check("to_frozen_stall", 64'(stallA), 64'd0);
    resetDut();
    check("to_reset_err", 64'(errA), 64'd0);
    check("to_reset_wait", 64'(waitA), 64'd0);

    // ack on the 4th cycle wins over the threshold
    memReq = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    memAck = 1'b1;
    tick();
    check("ack_at_limit_err", 64'(errA), 64'd0);
    memAck = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("timer_cleared_err", 64'(errA), 64'd0);
    clearIn();
    tick();

    // saturation of the 2-bit counters
    resetDut();
    setLoadUse(5'd5);
    for (int i = 0; i < 5; i++) tick();
    check("sat_stallB", 64'(stallB), 64'd3);
    check("sat_stallA", 64'(stallA), 64'd5);
    clearIn();

    // reset in the middle of a wait leaves no residue
    memReq = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1 check("rst_mid_ctl", 64'(ctlA), 64'(C_OFF));
    tick();
    check("rst_mid_wait", 64'(waitA), 64'd0);
    check("rst_mid_stall", 64'(stallA), 64'd0);
    check("rst_mid_err", 64'(errA), 64'd0);
    rst = 1'b1;
    memReq = 1'b0;
    #1 check("rst_mid_run", 64'(ctlA), 64'(C_NORM));
    tick();
    memReq = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("no_residue_3", 64'(errA), 64'd0);
    tick();
    check("no_residue_4", 64'(errA), 64'd1);
    resetDut();
    tick();

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
